shift_rows_stream: RTL and testbench

//  Byte-serial AES ShiftRows / InvShiftRows permutation unit with valid/ready handshakes.

---
 rtl/shift_rows_stream.sv | 114 +++++++++++
 tb/tb_shift_rows_stream.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_stream.sv
// rtl/shift_rows_stream.sv - byte-serial AES ShiftRows/InvShiftRows/bypass unit
// Two 16-lane banks ping-pong so one block is written while the other is read out.
module shift_rows_stream #(
    parameter int DW    = 8,
    parameter int NBYTE = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [1:0]    out_mode
);

    localparam logic [3:0] LAST_IDX = 4'(NBYTE - 1);

    logic [DW-1:0] bank_q [2][NBYTE];
    logic [1:0]    mode_q [2];
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [3:0]    wr_idx_q, wr_idx_d;
    logic [3:0]    rd_idx_q, rd_idx_d;
    logic          wr_fire, rd_fire;
    logic [3:0]    rd_src;

    // Lane k sits at row k[1:0], column k[3:2]; rows rotate by their row number.
    function automatic logic [3:0] src_idx(input logic [3:0] k, input logic [1:0] m);
        logic [1:0] r;
        logic [1:0] c;
        r = k[1:0];
        c = k[3:2];
        if (m[1]) begin
            src_idx = k;
        end else if (m[0]) begin
            src_idx = {c - r, r};
        end else begin
            src_idx = {c + r, r};
        end
    endfunction

    always_comb begin
        in_ready  = !full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        wr_fire   = in_valid && in_ready;
        rd_fire   = out_valid && out_ready;
        rd_src    = src_idx(rd_idx_q, mode_q[rd_bank_q]);
        out_data  = bank_q[rd_bank_q][rd_src];
        out_last  = out_valid && (rd_idx_q == LAST_IDX);
        out_mode  = mode_q[rd_bank_q];

        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;

        if (wr_fire) begin
            wr_idx_d = wr_idx_q + 4'd1;
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d          = 4'd0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        // Set and clear never hit the same bank: writes need the bank empty, reads need it full.
        if (rd_fire) begin
            rd_idx_d = rd_idx_q + 4'd1;
            if (rd_idx_q == LAST_IDX) begin
                rd_idx_d          = 4'd0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                mode_q[b] <= 2'b00;
                for (int i = 0; i < NBYTE; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (wr_fire) begin
            bank_q[wr_bank_q][wr_idx_q] <= in_data;
            if (wr_idx_q == 4'd0) begin
                mode_q[wr_bank_q] <= in_mode;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// tb/tb_shift_rows_stream.sv - self-checking bench for shift_rows_stream
module tb_shift_rows_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] out_mode;

    always #5 clk = ~clk;

    shift_rows_stream #(.DW(8), .NBYTE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_mode  (out_mode)
    );

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        logic       l;
    } lane_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    lane_t      exp_q[$];
    logic [7:0] part_q[$];
    logic [1:0] part_mode = 2'b00;
    int         acc_cnt = 0;
    logic [7:0] got_q[$];
    bit         chk_en = 0;
    bit         mon_en = 0;
    int         drops = 0;
    int         run_len = 0;
    int         max_run = 0;

    logic [7:0] fwd_lit [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                 8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    logic [7:0] inv_lit [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                 8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    logic [1:0] t4_modes [4] = '{2'b00, 2'b01, 2'b10, 2'b00};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // AES state view: output lane (r,c) takes input lane (r, c+r) fwd, (r, c-r) inv.
    function automatic int perm_src(input int k, input int m);
        int r;
        int c;
        int sc;
        r = k % 4;
        c = k / 4;
        if (m >= 2) sc = c;
        else if (m == 1) sc = (c - r + 4) % 4;
        else sc = (c + r) % 4;
        return 4 * sc + r;
    endfunction

    function automatic bit m_in_ready();
        return ((exp_q.size() + 15) / 16) < 2;
    endfunction

    always @(posedge clk) begin : model
        bit    di;
        bit    dout;
        lane_t e;
        if (rst) begin
            exp_q.delete();
            part_q.delete();
        end else begin
            di   = in_valid && m_in_ready();
            dout = out_ready && (exp_q.size() > 0);
            if (dout) void'(exp_q.pop_front());
            if (di) begin
                if (part_q.size() == 0) part_mode = in_mode;
                part_q.push_back(in_data);
                acc_cnt++;
                if (part_q.size() == 16) begin
                    for (int k = 0; k < 16; k++) begin
                        e.d = part_q[perm_src(k, int'(part_mode))];
                        e.m = part_mode;
                        e.l = (k == 15);
                        exp_q.push_back(e);
                    end
                    part_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready()});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0].d});
                chk("out_mode", {30'd0, out_mode}, {30'd0, exp_q[0].m});
                chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0].l});
                if (out_ready && out_valid) got_q.push_back(out_data);
            end else begin
                chk("out_last_idle", {31'd0, out_last}, 32'd0);
            end
        end
        if (mon_en && !in_ready) drops++;
        if (out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for lane %0h", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [7:0] base, input logic [1:0] m);
        for (int i = 0; i < 16; i++) send(base + 8'(i), m);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = 8'($urandom);
            in_mode = 2'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            in_mode  = 2'($urandom);
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        got_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
        chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_out_mode"}, {30'd0, out_mode}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_mode   = 2'd0;
        out_ready = 1'b1;

        // T1 reset
        do_reset(2);
        chk_en = 1;
        chk_reset_outputs("t1");

        chk("pin_fwd_1", perm_src(1, 0), 5);
        chk("pin_inv_1", perm_src(1, 1), 13);
        chk("pin_fwd_15", perm_src(15, 0), 11);
        chk("pin_byp_9", perm_src(9, 2), 9);

        // T2 forward
        send_block(8'h00, 2'b00);
        idle(20);
        chk("t2_count", got_q.size(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("t2_lane%0d", i), {24'd0, got_q[i]}, {24'd0, fwd_lit[i]});

        // T3 inverse and bypass
        got_q.delete();
        send_block(8'h00, 2'b01);
        idle(20);
        chk("t3_count", got_q.size(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("t3_lane%0d", i), {24'd0, got_q[i]}, {24'd0, inv_lit[i]});
        got_q.delete();
        send_block(8'h00, 2'b10);
        idle(20);
        chk("byp_count", got_q.size(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("byp_lane%0d", i), {24'd0, got_q[i]}, i);

        // T4 streaming
        got_q.delete();
        drops   = 0;
        max_run = 0;
        mon_en  = 1;
        for (int b = 0; b < 4; b++) send_block(8'h40 + 8'(16 * b), t4_modes[b]);
        mon_en = 0;
        idle(25);
        chk("t4_in_ready_drops", drops, 0);
        chk("t4_out_run", max_run, 64);
        chk("t4_count", got_q.size(), 64);
        chk("t4_blk1_lane1", {24'd0, got_q[17]}, 32'h5D);
        chk("t4_blk2_lane5", {24'd0, got_q[37]}, 32'h65);
        chk("t4_blk3_lane15", {24'd0, got_q[63]}, 32'h7B);

        // T5 backpressure
        got_q.delete();
        acc0      = acc_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if (i < 16) send(8'h80 + 8'(i), 2'b00);
                    else if (i < 32) send(8'hA0 + 8'(i - 16), 2'b01);
                    else send(8'hC0 + 8'(i - 32), 2'b00);
                end
            end
            begin
                repeat (45) begin
                    @(posedge clk);
                    #1;
                end
                chk("t5_stalled_accepted", acc_cnt - acc0, 32);
                chk("t5_stalled_in_ready", {31'd0, in_ready}, 32'd0);
                chk("t5_stalled_out_valid", {31'd0, out_valid}, 32'd1);
                out_ready = 1'b1;
            end
        join
        idle(40);
        chk("t5_accepted", acc_cnt - acc0, 40);
        chk("t5_count", got_q.size(), 32);
        chk("t5_blk1_lane1", {24'd0, got_q[1]}, 32'h85);
        chk("t5_blk2_lane1", {24'd0, got_q[17]}, 32'hAD);
        chk("t5_partial_no_out", {31'd0, out_valid}, 32'd0);

        // T6 reset mid-operation
        do_reset(1);
        send_block(8'h10, 2'b00);
        for (int i = 0; i < 7; i++) send(8'h20 + 8'(i), 2'b01);
        chk("t6_pre_out_valid", {31'd0, out_valid}, 32'd1);
        do_reset(1);
        chk_reset_outputs("t6");
        send_block(8'h00, 2'b00);
        idle(20);
        chk("t6_count", got_q.size(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("t6_lane%0d", i), {24'd0, got_q[i]}, {24'd0, fwd_lit[i]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
